// File: rtl/btn_conditioner.sv
// N-channel push-button front end: 2-flop synchroniser, tick-based debounce,
// press/release pulses, and long-press detection with auto-repeat.
module btn_conditioner #(
  parameter int N_CH       = 2,
  parameter int SAMPLE_DIV = 1,
  parameter int DB_CNT     = 4,
  parameter int HOLD_TICKS = 500,
  parameter int RPT_TICKS  = 100
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_rpt,
  output logic [N_CH-1:0] o_long_hold
);

  localparam int DB_W   = $clog2(DB_CNT + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int RPT_W  = $clog2(RPT_TICKS + 1);

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic            w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // A divide-by-one tick needs no counter at all.
  generate
    if (SAMPLE_DIV == 1) begin : g_noDiv
      assign w_tick = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(SAMPLE_DIV);
      logic [DIV_W-1:0] r_divCnt;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_divCnt <= '0;
        end else if (r_divCnt == DIV_W'(SAMPLE_DIV - 1)) begin
          r_divCnt <= '0;
        end else begin
          r_divCnt <= r_divCnt + DIV_W'(1);
        end
      end

      assign w_tick = (r_divCnt == DIV_W'(SAMPLE_DIV - 1));
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      logic              r_level;
      logic              r_press;
      logic              r_release;
      logic              r_rpt;
      logic              r_longHold;
      logic [DB_W-1:0]   r_dbCnt;
      logic [HOLD_W-1:0] r_holdCnt;
      logic [RPT_W-1:0]  r_rptCnt;
      logic              w_differ;
      logic              w_flip;
      logic              w_holdDone;

      assign w_differ   = r_sync2[i] ^ r_level;
      assign w_flip     = w_tick & w_differ & (r_dbCnt == DB_W'(DB_CNT - 1));
      assign w_holdDone = (r_holdCnt == HOLD_W'(HOLD_TICKS));

      // Hold tracking restarts on the press edge and is dropped on the release edge.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_level    <= 1'b0;
          r_press    <= 1'b0;
          r_release  <= 1'b0;
          r_rpt      <= 1'b0;
          r_longHold <= 1'b0;
          r_dbCnt    <= '0;
          r_holdCnt  <= '0;
          r_rptCnt   <= '0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_rpt     <= 1'b0;
          if (w_tick) begin
            if (!w_differ) begin
              r_dbCnt <= '0;
            end else if (w_flip) begin
              r_level   <= ~r_level;
              r_dbCnt   <= '0;
              r_press   <= ~r_level;
              r_release <= r_level;
            end else begin
              r_dbCnt <= r_dbCnt + DB_W'(1);
            end

            if (!r_level || w_flip) begin
              r_holdCnt  <= '0;
              r_rptCnt   <= '0;
              r_longHold <= 1'b0;
            end else if (!w_holdDone) begin
              r_holdCnt <= r_holdCnt + HOLD_W'(1);
              if (r_holdCnt == HOLD_W'(HOLD_TICKS - 1)) begin
                r_longHold <= 1'b1;
                r_rpt      <= 1'b1;
              end
            end else if (r_rptCnt == RPT_W'(RPT_TICKS - 1)) begin
              r_rptCnt <= '0;
              r_rpt    <= 1'b1;
            end else begin
              r_rptCnt <= r_rptCnt + RPT_W'(1);
            end
          end
        end
      end

      assign o_level[i]     = r_level;
      assign o_press[i]     = r_press;
      assign o_release[i]   = r_release;
      assign o_rpt[i]       = r_rpt;
      assign o_long_hold[i] = r_longHold;
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: three parameterisations against a behavioural model
// that tracks debounce runs and unbounded hold durations per channel.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn [3];
  wire  [9:0] outA;
  wire  [9:0] outB;
  wire  [9:0] outC;

  int nChecks = 0;
  int nFails  = 0;

  int pDiv  [3];
  int pDb   [3];
  int pHold [3];
  int pRpt  [3];

  btn_conditioner #(.N_CH(2), .SAMPLE_DIV(1), .DB_CNT(4), .HOLD_TICKS(500), .RPT_TICKS(100)) dutA (
    .i_clk(clk), .i_rst(rst), .i_btn_in(btn[0]),
    .o_level(outA[1:0]), .o_press(outA[3:2]), .o_release(outA[5:4]),
    .o_rpt(outA[7:6]), .o_long_hold(outA[9:8]));

  btn_conditioner #(.N_CH(2), .SAMPLE_DIV(4), .DB_CNT(4), .HOLD_TICKS(6), .RPT_TICKS(2)) dutB (
    .i_clk(clk), .i_rst(rst), .i_btn_in(btn[1]),
    .o_level(outB[1:0]), .o_press(outB[3:2]), .o_release(outB[5:4]),
    .o_rpt(outB[7:6]), .o_long_hold(outB[9:8]));

  btn_conditioner #(.N_CH(2), .SAMPLE_DIV(1), .DB_CNT(4), .HOLD_TICKS(10), .RPT_TICKS(3)) dutC (
    .i_clk(clk), .i_rst(rst), .i_btn_in(btn[2]),
    .o_level(outC[1:0]), .o_press(outC[3:2]), .o_release(outC[5:4]),
    .o_rpt(outC[7:6]), .o_long_hold(outC[9:8]));

  always #5 clk = ~clk;

  bit mS1    [3][2];
  bit mS2    [3][2];
  bit mLevel [3][2];
  bit mPress [3][2];
  bit mRel   [3][2];
  bit mRptQ  [3][2];
  bit mLong  [3][2];
  int mRun   [3][2];
  int mHeld  [3][2];
  int mN     [3];

  // Reference: debounce as a run of differing samples, hold as an unbounded tick count.
  always @(posedge clk) begin : model
    bit tk;
    bit was;
    for (int d = 0; d < 3; d++) begin
      tk = ((mN[d] % pDiv[d]) == pDiv[d] - 1);
      if (rst) mN[d] = 0;
      else     mN[d] = mN[d] + 1;
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          mS1[d][c] = 0; mS2[d][c] = 0; mLevel[d][c] = 0; mPress[d][c] = 0;
          mRel[d][c] = 0; mRptQ[d][c] = 0; mLong[d][c] = 0;
          mRun[d][c] = 0; mHeld[d][c] = 0;
        end else begin
          was = mLevel[d][c];
          mPress[d][c] = 0; mRel[d][c] = 0; mRptQ[d][c] = 0;
          if (tk) begin
            if (mS2[d][c] != was) begin
              mRun[d][c] = mRun[d][c] + 1;
              if (mRun[d][c] == pDb[d]) begin
                mLevel[d][c] = !was;
                mPress[d][c] = !was;
                mRel[d][c]   = was;
                mRun[d][c]   = 0;
              end
            end else begin
              mRun[d][c] = 0;
            end
            if (was && mLevel[d][c]) begin
              mHeld[d][c] = mHeld[d][c] + 1;
              mLong[d][c] = (mHeld[d][c] >= pHold[d]);
              mRptQ[d][c] = (mHeld[d][c] >= pHold[d]) && (((mHeld[d][c] - pHold[d]) % pRpt[d]) == 0);
            end else begin
              mHeld[d][c] = 0;
              mLong[d][c] = 0;
            end
          end
          mS2[d][c] = mS1[d][c];
          mS1[d][c] = btn[d][c];
        end
      end
    end
  end

  function automatic logic [9:0] modelVec(int d);
    logic [9:0] v;
    v = '0;
    for (int c = 0; c < 2; c++) begin
      v[c]     = mLevel[d][c];
      v[2 + c] = mPress[d][c];
      v[4 + c] = mRel[d][c];
      v[6 + c] = mRptQ[d][c];
      v[8 + c] = mLong[d][c];
    end
    return v;
  endfunction

  function automatic logic [9:0] dutVec(int d);
    case (d)
      0:       return outA;
      1:       return outB;
      default: return outC;
    endcase
  endfunction

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(int n);
    for (int i = 0; i < n; i++) waitEdge();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    btn[0] = 2'b00; btn[1] = 2'b00; btn[2] = 2'b00;
    waitEdge();
    waitEdge();
    for (int d = 0; d < 3; d++) begin
      nChecks++;
      if (dutVec(d) !== 10'b0) begin
        nFails++;
        $display("[TB] FAIL reset_state dut%0d: got %b expected %b", d, dutVec(d), 10'b0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_step();
    @(negedge clk);
    btn[0] = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      waitEdge();
      nChecks++;
      if (outA !== modelVec(0)) begin
        nFails++;
        $display("[TB] FAIL step_model cyc%0d: got %b expected %b", i, outA, modelVec(0));
      end
      nChecks++;
      if ({outA[9], outA[7], outA[5], outA[3], outA[1]} !== 5'b0) begin
        nFails++;
        $display("[TB] FAIL step_ch1_silent cyc%0d: got %b expected 00000", i,
                 {outA[9], outA[7], outA[5], outA[3], outA[1]});
      end
      if (i == 5) begin
        nChecks++;
        if (outA[0] !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL step_early_level: got %b expected 0", outA[0]);
        end
      end
      if (i == 6) begin
        nChecks++;
        if ({outA[2], outA[0]} !== 2'b11) begin
          nFails++;
          $display("[TB] FAIL step_press_level: got %b expected 11", {outA[2], outA[0]});
        end
      end
      if (i == 7) begin
        nChecks++;
        if ({outA[2], outA[0]} !== 2'b01) begin
          nFails++;
          $display("[TB] FAIL step_press_width: got %b expected 01", {outA[2], outA[0]});
        end
      end
    end
    @(negedge clk);
    btn[0] = 2'b00;
    runCycles(10);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    btn[0] = 2'b01;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) begin
        @(negedge clk);
        btn[0] = 2'b00;
      end
      waitEdge();
      nChecks++;
      if ({outA[4], outA[2], outA[0]} !== 3'b000) begin
        nFails++;
        $display("[TB] FAIL glitch_quiet cyc%0d: got %b expected 000", i, {outA[4], outA[2], outA[0]});
      end
      nChecks++;
      if (outA !== modelVec(0)) begin
        nFails++;
        $display("[TB] FAIL glitch_model cyc%0d: got %b expected %b", i, outA, modelVec(0));
      end
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    btn[0] = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      waitEdge();
      nChecks++;
      if (outA[3:2] !== ((i == 6) ? 2'b11 : 2'b00)) begin
        nFails++;
        $display("[TB] FAIL simul_press cyc%0d: got %b expected %b", i, outA[3:2],
                 (i == 6) ? 2'b11 : 2'b00);
      end
      nChecks++;
      if (outA !== modelVec(0)) begin
        nFails++;
        $display("[TB] FAIL simul_model cyc%0d: got %b expected %b", i, outA, modelVec(0));
      end
    end
    @(negedge clk);
    btn[0] = 2'b00;
    runCycles(10);
  endtask

  task automatic test_release();
    bit seen;
    int firstRel;
    int relCount;
    int pressCount;
    @(negedge clk);
    btn[1] = 2'b01;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      waitEdge();
      nChecks++;
      if (outB !== modelVec(1)) begin
        nFails++;
        $display("[TB] FAIL rel_model_rise cyc%0d: got %b expected %b", i, outB, modelVec(1));
      end
      if (outB[0]) seen = 1;
    end
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("[TB] FAIL rel_rise_timeout: got level 0 expected 1 within 60 cycles");
      return;
    end
    runCycles(3);
    @(negedge clk);
    btn[1] = 2'b00;
    firstRel = -1; relCount = 0; pressCount = 0;
    for (int i = 1; i <= 24; i++) begin
      waitEdge();
      nChecks++;
      if (outB !== modelVec(1)) begin
        nFails++;
        $display("[TB] FAIL rel_model_fall cyc%0d: got %b expected %b", i, outB, modelVec(1));
      end
      if (outB[4]) begin
        relCount++;
        if (firstRel < 0) firstRel = i;
      end
      if (outB[2]) pressCount++;
    end
    nChecks++;
    if (relCount != 1) begin
      nFails++;
      $display("[TB] FAIL rel_pulse_count: got %0d expected 1", relCount);
    end
    nChecks++;
    if (firstRel < 1 || firstRel > 18) begin
      nFails++;
      $display("[TB] FAIL rel_latency: got %0d expected 1..18", firstRel);
    end
    nChecks++;
    if (pressCount != 0) begin
      nFails++;
      $display("[TB] FAIL rel_no_press: got %0d expected 0", pressCount);
    end
  endtask

  task automatic test_auto_repeat();
    bit seen;
    int relAt;
    @(negedge clk);
    btn[2] = 2'b01;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      waitEdge();
      if (outC[2]) seen = 1;
    end
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("[TB] FAIL rpt_press_timeout: got no press expected press within 20 cycles");
      return;
    end
    for (int t = 1; t <= 30; t++) begin
      waitEdge();
      nChecks++;
      if (outC[6] !== ((t >= 10) && ((t - 10) % 3 == 0))) begin
        nFails++;
        $display("[TB] FAIL rpt_pulse t%0d: got %b expected %b", t, outC[6],
                 (t >= 10) && ((t - 10) % 3 == 0));
      end
      nChecks++;
      if (outC[8] !== (t >= 10)) begin
        nFails++;
        $display("[TB] FAIL rpt_long_hold t%0d: got %b expected %b", t, outC[8], t >= 10);
      end
      nChecks++;
      if (outC !== modelVec(2)) begin
        nFails++;
        $display("[TB] FAIL rpt_model t%0d: got %b expected %b", t, outC, modelVec(2));
      end
    end
    @(negedge clk);
    btn[2] = 2'b00;
    relAt = -1;
    for (int i = 1; i <= 15; i++) begin
      waitEdge();
      if (outC[4]) relAt = i;
      if (relAt >= 0) begin
        nChecks++;
        if ({outC[8], outC[6]} !== 2'b00) begin
          nFails++;
          $display("[TB] FAIL rpt_after_release cyc%0d: got %b expected 00", i, {outC[8], outC[6]});
        end
      end
      nChecks++;
      if (outC !== modelVec(2)) begin
        nFails++;
        $display("[TB] FAIL rpt_model_rel cyc%0d: got %b expected %b", i, outC, modelVec(2));
      end
    end
    nChecks++;
    if (relAt < 0) begin
      nFails++;
      $display("[TB] FAIL rpt_release_timeout: got no release expected one within 15 cycles");
    end
  endtask

  task automatic test_reset_mid_hold();
    bit seen;
    @(negedge clk);
    btn[2] = 2'b10;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      waitEdge();
      if (outC[9] && outC[1]) seen = 1;
    end
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("[TB] FAIL midrst_hold_timeout: got no long_hold expected one within 40 cycles");
      return;
    end
    @(negedge clk);
    rst = 1'b1;
    waitEdge();
    nChecks++;
    if (outC !== 10'b0) begin
      nFails++;
      $display("[TB] FAIL midrst_clear: got %b expected %b", outC, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      waitEdge();
      nChecks++;
      if (outC[3] !== (i == 6)) begin
        nFails++;
        $display("[TB] FAIL midrst_repress cyc%0d: got %b expected %b", i, outC[3], i == 6);
      end
      nChecks++;
      if (outC[5] !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL midrst_no_release cyc%0d: got %b expected 0", i, outC[5]);
      end
    end
    @(negedge clk);
    btn[2] = 2'b00;
    runCycles(10);
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 7) == 0) begin
          k = $urandom_range(0, 1);
          btn[d][k] = ~btn[d][k];
        end
      end
      waitEdge();
      for (int d = 0; d < 3; d++) begin
        nChecks++;
        if (dutVec(d) !== modelVec(d)) begin
          nFails++;
          $display("[TB] FAIL random_model dut%0d cyc%0d: got %b expected %b", d, i, dutVec(d), modelVec(d));
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    pDiv  = '{1, 4, 1};
    pDb   = '{4, 4, 4};
    pHold = '{500, 6, 10};
    pRpt  = '{100, 2, 3};
    btn[0] = 2'b00; btn[1] = 2'b00; btn[2] = 2'b00;
    test_reset();
    test_clean_step();
    test_glitch();
    test_simultaneous();
    test_release();
    test_auto_repeat();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
